// File: rtl/cmp_seq_pkg.sv
// Shared types for the sequential 32-bit branch-condition resolver.
package cmp_seq_pkg;

  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    DONE
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_seq_32_cmp_16.sv
// 16-bit unsigned magnitude comparator shared by both operand halves.
module cmp_16
  import cmp_seq_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic              equal,
  output logic              blarger
);

  assign equal   = (a == b);
  assign blarger = (a < b);

endmodule

// File: rtl/cmp_seq_32.sv
// Multi-cycle 32-bit branch resolver reusing one cmp_16 over both halves.
// Build option: define CMP_SEQ_EARLY_OUT_EN to skip the low half when the high halves differ.
module cmp_seq_32
  import cmp_seq_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic        taken_o,
  output logic        eq_o,
  output logic        lt_o,
  output logic        illegal_o
);

  state_t      state;
  logic [31:0] a_q, b_q;
  logic [2:0]  f3_q;

  logic [HALF_W-1:0] op_a, op_b;
  logic              cmp_eq, cmp_lt;
  logic              res_eq, res_lt;

`ifndef CMP_SEQ_EARLY_OUT_EN
  logic hi_diff_q, hi_lt_q;
`endif

  // Flipping the sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    op_a = a_q[HALF_W-1:0];
    op_b = b_q[HALF_W-1:0];
    if (state == HI) begin
      op_a = a_q[31:HALF_W];
      op_b = b_q[31:HALF_W];
      if (!f3_q[1]) begin
        op_a[HALF_W-1] = ~op_a[HALF_W-1];
        op_b[HALF_W-1] = ~op_b[HALF_W-1];
      end
    end
  end

  cmp_16 u_cmp (
    .a       (op_a),
    .b       (op_b),
    .equal   (cmp_eq),
    .blarger (cmp_lt)
  );

  always_comb begin
    res_eq = cmp_eq;
    res_lt = cmp_lt;
    if (state == HI) begin
      res_eq = 1'b0;
`ifndef CMP_SEQ_EARLY_OUT_EN
    end else begin
      res_eq = ~hi_diff_q & cmp_eq;
      res_lt = hi_diff_q ? hi_lt_q : cmp_lt;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      taken_o      <= 1'b0;
      eq_o         <= 1'b0;
      lt_o         <= 1'b0;
      illegal_o    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      f3_q         <= '0;
`ifndef CMP_SEQ_EARLY_OUT_EN
      hi_diff_q    <= 1'b0;
      hi_lt_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          a_q         <= a_i;
          b_q         <= b_i;
          f3_q        <= funct3_i;
          req_ready_o <= 1'b0;
          state       <= HI;
        end
        HI: begin
`ifdef CMP_SEQ_EARLY_OUT_EN
          if (!cmp_eq) begin
            eq_o         <= res_eq;
            lt_o         <= res_lt;
            taken_o      <= f3_taken(f3_q, res_eq, res_lt);
            illegal_o    <= f3_illegal(f3_q);
            resp_valid_o <= 1'b1;
            state        <= DONE;
          end else begin
            state <= LO;
          end
`else
          hi_diff_q <= ~cmp_eq;
          hi_lt_q   <= cmp_lt;
          state     <= LO;
`endif
        end
        LO: begin
          eq_o         <= res_eq;
          lt_o         <= res_lt;
          taken_o      <= f3_taken(f3_q, res_eq, res_lt);
          illegal_o    <= f3_illegal(f3_q);
          resp_valid_o <= 1'b1;
          state        <= DONE;
        end
        DONE: if (resp_ready_i) begin
          resp_valid_o <= 1'b0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_seq_32.sv
// Scoreboard bench for cmp_seq_32: latency, result fields, backpressure, reset abort.
module tb_cmp_seq_32;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, resp_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  f3 = '0;
  logic        req_ready, resp_valid, taken, eq, lt, illegal;

  typedef struct packed {
    logic       taken;
    logic       eq;
    logic       lt;
    logic       illegal;
    logic [3:0] lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cmp_seq_32 dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .a_i          (a),
    .b_i          (b),
    .funct3_i     (f3),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .taken_o      (taken),
    .eq_o         (eq),
    .lt_o         (lt),
    .illegal_o    (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] mf);
    exp_t e;
    e.eq      = (ma == mb);
    e.lt      = mf[1] ? (ma < mb) : ($signed(ma) < $signed(mb));
    e.illegal = (mf == 3'b010) || (mf == 3'b011);
    case (mf)
      3'b000:         e.taken = e.eq;
      3'b001:         e.taken = !e.eq;
      3'b100, 3'b110: e.taken = e.lt;
      3'b101, 3'b111: e.taken = !e.lt;
      default:        e.taken = 1'b0;
    endcase
`ifdef CMP_SEQ_EARLY_OUT_EN
    e.lat = (ma[31:16] != mb[31:16]) ? 4'd2 : 4'd3;
`else
    e.lat = 4'd3;
`endif
    return e;
  endfunction

  // Latency counts cycles from the accept cycle to the first resp_valid cycle.
  task automatic run(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tf,
                     input int hold, input bit abort);
    int n;
    exp_t e;
    logic [3:0] snap;
    chk("req_ready_idle", req_ready, 1);
    a = ta; b = tb; f3 = tf; req_valid = 1'b1;
    resp_ready = (hold == 0);
    if (!abort) sb.push_back(model(ta, tb, tf));
    @(posedge clk); #1;
    req_valid = 1'b0;
    a = $urandom; b = $urandom; f3 = 3'($urandom);
    if (abort) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      repeat (6) begin
        @(posedge clk); #1;
        chk("no_resp_after_rst", resp_valid, 0);
      end
      return;
    end
    n = 1;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", resp_valid, 1);
      sb.delete();
      return;
    end
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk("taken", taken, e.taken);
    chk("eq", eq, e.eq);
    chk("lt", lt, e.lt);
    chk("illegal", illegal, e.illegal);
    if (hold > 0) begin
      snap = {taken, eq, lt, illegal};
      repeat (hold) begin
        @(posedge clk); #1;
        chk("bp_stable", {taken, eq, lt, illegal}, snap);
        chk("bp_valid", resp_valid, 1);
        chk("bp_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] codes [8];
    logic [31:0] ra, rb;
    codes = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_flags", {taken, eq, lt, illegal}, 0);

    run(32'h1234_5678, 32'h1234_5678, 3'b000, 0, 0);
    run(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0, 0);
    run(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0, 0);
    run(32'h0001_0000, 32'h0001_FFFF, 3'b111, 0, 0);
    run(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0, 0);
    run(32'h0000_0000, 32'h0000_0000, 3'b011, 0, 0);
    run(32'h0000_0005, 32'h0000_0007, 3'b001, 5, 0);
    run(32'h1111_0000, 32'h2222_0000, 3'b100, 0, 1);
    run(32'hFFFF_0001, 32'hFFFF_8000, 3'b100, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb[31:16] = ra[31:16];
      if (i % 6 == 3) rb = ra;
      run(ra, rb, codes[$urandom_range(7, 0)], (i % 5 == 4) ? 2 : 0, 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
